// File: rtl/im_arbiter.sv
// rtl/im_arbiter.sv - image memory arbiter: display reads have absolute priority, CPU writes drain from a FIFO
// Every mem_* output is registered; display data returns a fixed 3 edges after the request is sampled.
module im_arbiter #(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int ADDR_W      = 19,
  parameter int DATA_W      = 12,
  parameter int WFIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [9:0]        disp_x,
  input  logic [9:0]        disp_y,
  output logic [DATA_W-1:0] disp_rgb,
  output logic              disp_valid,
  input  logic              cpu_valid,
  output logic              cpu_ready,
  input  logic [9:0]        cpu_x,
  input  logic [9:0]        cpu_y,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_oob,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int               PTR_W    = $clog2(WFIFO_DEPTH);
  localparam logic [10:0]      H_LIM    = 11'(H_RES);
  localparam logic [10:0]      V_LIM    = 11'(V_RES);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(WFIFO_DEPTH);

  typedef enum logic [1:0] {GRANT_IDLE, GRANT_DISP, GRANT_CPU} grant_t;

  function automatic logic in_range(input logic [9:0] x, input logic [9:0] y);
    return ({1'b0, x} < H_LIM) && ({1'b0, y} < V_LIM);
  endfunction

  // Constant multiplier; reduces to shift-and-add for the default 640-wide frame.
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [9:0] x, input logic [9:0] y);
    return ADDR_W'(y) * ADDR_W'(H_RES) + ADDR_W'(x);
  endfunction

  logic [ADDR_W-1:0] fifo_addr [WFIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [WFIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              disp_ok;
  logic              cpu_ok;
  logic              push_any;
  logic              push;
  logic              pop;
  grant_t            grant;
  logic              tag1_valid;
  logic              tag1_oob;
  logic              tag2_valid;
  logic              tag2_oob;

  assign disp_ok   = in_range(disp_x, disp_y);
  assign cpu_ok    = in_range(cpu_x, cpu_y);
  assign cpu_ready = (count != FULL_CNT);
  assign push_any  = cpu_valid && cpu_ready;
  assign push      = push_any && cpu_ok;

  // Registered occupancy means a write pushed this cycle cannot be popped until the next.
  always_comb begin
    grant = GRANT_IDLE;
    if (disp_req && disp_ok) begin
      grant = GRANT_DISP;
    end else if (count != '0) begin
      grant = GRANT_CPU;
    end
  end

  assign pop = (grant == GRANT_CPU);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= pix_addr(cpu_x, cpu_y);
      fifo_data[wr_ptr] <= cpu_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      cpu_oob <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop) begin
        count <= count + (PTR_W+1)'(1);
      end else if (pop && !push) begin
        count <= count - (PTR_W+1)'(1);
      end
      if (push_any && !cpu_ok) cpu_oob <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (grant)
        GRANT_DISP: begin
          mem_en    <= 1'b1;
          mem_we    <= 1'b0;
          mem_addr  <= pix_addr(disp_x, disp_y);
          mem_wdata <= '0;
        end
        GRANT_CPU: begin
          mem_en    <= 1'b1;
          mem_we    <= 1'b1;
          mem_addr  <= fifo_addr[rd_ptr];
          mem_wdata <= fifo_data[rd_ptr];
        end
        default: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
        end
      endcase
    end
  end

  // Tag pipeline tracks each request, including out-of-range ones that never touch memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag1_valid <= 1'b0;
      tag1_oob   <= 1'b0;
      tag2_valid <= 1'b0;
      tag2_oob   <= 1'b0;
      disp_valid <= 1'b0;
      disp_rgb   <= '0;
    end else begin
      tag1_valid <= disp_req;
      tag1_oob   <= !disp_ok;
      tag2_valid <= tag1_valid;
      tag2_oob   <= tag1_oob;
      disp_valid <= tag2_valid;
      disp_rgb   <= (tag2_valid && !tag2_oob) ? mem_rdata : '0;
    end
  end

endmodule

// File: tb/tb_im_arbiter.sv
// tb/tb_im_arbiter.sv - self-checking bench for im_arbiter with a memory model and scoreboards
// Inputs change 2 ns after the rising edge; the monitor samples on the falling edge.
module tb_im_arbiter;

  typedef struct {
    int          x;
    int          y;
    int          c;
    bit          oob;
    logic [11:0] exp;
  } disp_t;

  typedef struct {
    int          addr;
    logic [11:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        disp_req = 1'b0;
  logic [9:0]  disp_x = '0;
  logic [9:0]  disp_y = '0;
  logic [11:0] disp_rgb;
  logic        disp_valid;
  logic        cpu_valid = 1'b0;
  logic        cpu_ready;
  logic [9:0]  cpu_x = '0;
  logic [9:0]  cpu_y = '0;
  logic [11:0] cpu_wdata = '0;
  logic        cpu_oob;
  logic        mem_en;
  logic        mem_we;
  logic [18:0] mem_addr;
  logic [11:0] mem_wdata;
  logic [11:0] mem_rdata = '0;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          we_seen = 0;
  int          dv_seen = 0;
  disp_t       req_q[$];
  disp_t       exp_q[$];
  wr_t         write_q[$];
  disp_t       mon_e;
  wr_t         mon_w;
  logic [11:0] wr_mem [int];

  im_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .disp_req   (disp_req),
    .disp_x     (disp_x),
    .disp_y     (disp_y),
    .disp_rgb   (disp_rgb),
    .disp_valid (disp_valid),
    .cpu_valid  (cpu_valid),
    .cpu_ready  (cpu_ready),
    .cpu_x      (cpu_x),
    .cpu_y      (cpu_y),
    .cpu_wdata  (cpu_wdata),
    .cpu_oob    (cpu_oob),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [11:0] mem_val(input int a);
    if (wr_mem.exists(a)) return wr_mem[a];
    return 12'(a * 7 + (a >> 12));
  endfunction

  // Synchronous single-port memory: read data appears the cycle after mem_en.
  always @(posedge clk) begin
    if (mem_en === 1'b1) begin
      if (mem_we === 1'b1) wr_mem[int'(mem_addr)] = mem_wdata;
      else mem_rdata <= mem_val(int'(mem_addr));
    end
  end

  always @(negedge clk) begin
    if (req_q.size() > 0 && req_q[0].c == cyc - 1) begin
      mon_e = req_q.pop_front();
      checks++;
      if (mon_e.oob) begin
        mon_e.exp = 12'h000;
        if (mem_en === 1'b1 && mem_we === 1'b0) begin
          errors++;
          $display("FAIL oob_no_read: mem read issued at addr %0d for (%0d,%0d), required none", mem_addr, mon_e.x, mon_e.y);
        end
      end else begin
        mon_e.exp = mem_val(mon_e.y * 640 + mon_e.x);
        if (!(mem_en === 1'b1 && mem_we === 1'b0 && mem_addr === 19'(mon_e.y * 640 + mon_e.x))) begin
          errors++;
          $display("FAIL disp_read_issue: en=%b we=%b addr=%0d, required en=1 we=0 addr=%0d", mem_en, mem_we, mem_addr, mon_e.y * 640 + mon_e.x);
        end
      end
      exp_q.push_back(mon_e);
    end
    if (disp_valid === 1'b1) begin
      dv_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL disp_unexpected: disp_valid=1 rgb=%h at cycle %0d, required no pulse", disp_rgb, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (cyc != mon_e.c + 3 || disp_rgb !== mon_e.exp) begin
          errors++;
          $display("FAIL disp_data: cycle %0d rgb=%h, required cycle %0d rgb=%h", cyc, disp_rgb, mon_e.c + 3, mon_e.exp);
        end
      end
    end else if (exp_q.size() > 0 && cyc >= exp_q[0].c + 3) begin
      mon_e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL disp_missing: disp_valid=%b at cycle %0d, required 1", disp_valid, cyc);
    end
    if (mem_en === 1'b1 && mem_we === 1'b1) begin
      we_seen++;
      checks++;
      if (write_q.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected: mem_we at addr %0d data %h, required no write", mem_addr, mem_wdata);
      end else begin
        mon_w = write_q.pop_front();
        if (mem_addr !== 19'(mon_w.addr) || mem_wdata !== mon_w.d) begin
          errors++;
          $display("FAIL write_order: addr=%0d data=%h, required addr=%0d data=%h", mem_addr, mem_wdata, mon_w.addr, mon_w.d);
        end
      end
    end
  end

  task automatic drive(input bit dreq, input int dx, input int dy, input bit cv,
                       input int cx, input int cy, input logic [11:0] wd, output bit acc);
    disp_t d;
    wr_t   w;
    @(posedge clk);
    #2;
    disp_req  = dreq;
    disp_x    = 10'(dx);
    disp_y    = 10'(dy);
    cpu_valid = cv;
    cpu_x     = 10'(cx);
    cpu_y     = 10'(cy);
    cpu_wdata = wd;
    acc = cv && (cpu_ready === 1'b1);
    if (dreq) begin
      d.x = dx; d.y = dy; d.c = cyc; d.oob = !(dx < 640 && dy < 480); d.exp = 12'h000;
      req_q.push_back(d);
    end
    if (acc && cx < 640 && cy < 480) begin
      w.addr = cy * 640 + cx; w.d = wd;
      write_q.push_back(w);
    end
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 12'h000, a);
  endtask

  task automatic wait_neg(input int t);
    do @(negedge clk); while (cyc < t);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    checks += 8;
    if (disp_valid !== 1'b0) begin errors++; $display("FAIL reset_disp_valid: %b, required 0", disp_valid); end
    if (disp_rgb !== 12'h000) begin errors++; $display("FAIL reset_disp_rgb: %h, required 000", disp_rgb); end
    if (mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en: %b, required 0", mem_en); end
    if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: %b, required 0", mem_we); end
    if (mem_addr !== 19'd0) begin errors++; $display("FAIL reset_mem_addr: %0d, required 0", mem_addr); end
    if (mem_wdata !== 12'h000) begin errors++; $display("FAIL reset_mem_wdata: %h, required 000", mem_wdata); end
    if (cpu_oob !== 1'b0) begin errors++; $display("FAIL reset_cpu_oob: %b, required 0", cpu_oob); end
    if (cpu_ready !== 1'b1) begin errors++; $display("FAIL reset_cpu_ready: %b, required 1", cpu_ready); end
    rst = 1'b0;
  endtask

  task automatic test_disp_corner;
    bit a;
    int t;
    drive(1, 639, 479, 0, 0, 0, 12'h000, a);
    t = cyc;
    idle(1);
    wait_neg(t + 1);
    checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 19'd307199) begin
      errors++;
      $display("FAIL corner_addr: en=%b we=%b addr=%0d, required en=1 we=0 addr=307199", mem_en, mem_we, mem_addr);
    end
    wait_neg(t + 3);
    checks++;
    if (disp_valid !== 1'b1 || disp_rgb !== mem_val(307199)) begin
      errors++;
      $display("FAIL corner_rgb: valid=%b rgb=%h, required valid=1 rgb=%h", disp_valid, disp_rgb, mem_val(307199));
    end
    idle(3);
  endtask

  task automatic test_disp_oob;
    bit a;
    int t;
    drive(1, 640, 0, 0, 0, 0, 12'h000, a);
    t = cyc;
    idle(1);
    wait_neg(t + 1);
    checks++;
    if (mem_en !== 1'b0) begin errors++; $display("FAIL oob_mem_en: %b, required 0", mem_en); end
    wait_neg(t + 3);
    checks++;
    if (disp_valid !== 1'b1 || disp_rgb !== 12'h000) begin
      errors++;
      $display("FAIL oob_blank: valid=%b rgb=%h, required valid=1 rgb=000", disp_valid, disp_rgb);
    end
    drive(1, 0, 480, 0, 0, 0, 12'h000, a);
    idle(5);
  endtask

  task automatic test_fifo_full;
    bit a;
    int acc_cnt = 0;
    int we0;
    we0 = we_seen;
    for (int i = 0; i < 5; i++) begin
      drive(1, i * 3, 5, 1, 20 + i, 7, 12'(12'h100 + i), a);
      acc_cnt += int'(a);
    end
    checks += 2;
    if (acc_cnt != 4) begin errors++; $display("FAIL full_accepted: %0d writes, required 4", acc_cnt); end
    if (cpu_ready !== 1'b0) begin errors++; $display("FAIL full_ready: %b, required 0", cpu_ready); end
    drive(1, 30, 6, 0, 0, 0, 12'h000, a);
    drive(1, 31, 6, 0, 0, 0, 12'h000, a);
    idle(2);
    checks++;
    if (we_seen != we0) begin errors++; $display("FAIL full_no_write: %0d writes during display burst, required 0", we_seen - we0); end
    idle(10);
    checks += 2;
    if (write_q.size() != 0) begin errors++; $display("FAIL full_drain: %0d writes pending, required 0", write_q.size()); end
    if (cpu_ready !== 1'b1) begin errors++; $display("FAIL full_ready_back: %b, required 1", cpu_ready); end
  endtask

  task automatic test_interleave;
    bit a;
    int t;
    for (int i = 0; i < 24; i++) begin
      if (i % 8 == 0) drive(1, 10, 2, 1, 10, 2, 12'hABC, a);
      else if (i % 4 == 0) drive(1, 100 + i, 3, 1, 10, 2, 12'hABC, a);
      else drive(0, 0, 0, 1, 10, 2, 12'hABC, a);
    end
    idle(8);
    checks++;
    if (write_q.size() != 0) begin errors++; $display("FAIL inter_drain: %0d writes pending, required 0", write_q.size()); end
    drive(1, 10, 2, 0, 0, 0, 12'h000, a);
    t = cyc;
    idle(1);
    wait_neg(t + 3);
    checks++;
    if (disp_valid !== 1'b1 || disp_rgb !== 12'hABC) begin
      errors++;
      $display("FAIL inter_readback: valid=%b rgb=%h, required valid=1 rgb=abc", disp_valid, disp_rgb);
    end
    idle(3);
  endtask

  task automatic test_oob_write_reset;
    bit a;
    int we0;
    int dv0;
    we0 = we_seen;
    drive(0, 0, 0, 1, 0, 480, 12'h555, a);
    idle(4);
    checks += 3;
    if (a !== 1'b1) begin errors++; $display("FAIL oobw_accept: %b, required 1", a); end
    if (cpu_oob !== 1'b1) begin errors++; $display("FAIL oobw_flag: %b, required 1", cpu_oob); end
    if (we_seen != we0) begin errors++; $display("FAIL oobw_no_write: %0d writes, required 0", we_seen - we0); end
    drive(1, 5, 5, 1, 1, 1, 12'h111, a);
    drive(1, 6, 5, 1, 2, 1, 12'h222, a);
    @(posedge clk);
    #2;
    rst = 1'b1; disp_req = 1'b0; cpu_valid = 1'b0;
    @(posedge clk);
    #2;
    req_q.delete(); exp_q.delete(); write_q.delete();
    we0 = we_seen;
    dv0 = dv_seen;
    checks += 4;
    if (cpu_oob !== 1'b0) begin errors++; $display("FAIL rst_cpu_oob: %b, required 0", cpu_oob); end
    if (cpu_ready !== 1'b1) begin errors++; $display("FAIL rst_cpu_ready: %b, required 1", cpu_ready); end
    if (mem_en !== 1'b0) begin errors++; $display("FAIL rst_mem_en: %b, required 0", mem_en); end
    if (disp_valid !== 1'b0) begin errors++; $display("FAIL rst_disp_valid: %b, required 0", disp_valid); end
    @(posedge clk);
    #2;
    rst = 1'b0;
    idle(10);
    checks += 2;
    if (we_seen != we0) begin errors++; $display("FAIL rst_stale_write: %0d writes, required 0", we_seen - we0); end
    if (dv_seen != dv0) begin errors++; $display("FAIL rst_stale_disp: %0d pulses, required 0", dv_seen - dv0); end
  endtask

  initial begin
    test_reset();
    test_disp_corner();
    test_disp_oob();
    test_fifo_full();
    test_interleave();
    test_oob_write_reset();
    checks++;
    if (req_q.size() + exp_q.size() + write_q.size() != 0) begin
      errors++;
      $display("FAIL final_queues: %0d entries left, required 0", req_q.size() + exp_q.size() + write_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached at cycle %0d, required completion", cyc);
    $fatal(1);
  end

endmodule
